fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 106 ++++++++++
 tb/tb_fetch_decode.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Single-issue fetch/decode stage: fetches one 16-bit instruction word at a time,
// holds it in an instruction register and presents its decoded fields downstream.
module fetch_decode #(
    parameter logic [0:15] RESET_PC = 16'h0000,
    parameter logic [0:4]  HALT_OP  = 5'b11111
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [0:15] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [0:15] i_mem_data,
    input  logic        i_redirect,
    input  logic [0:15] i_target,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [0:4]  o_opcode,
    output logic [0:1]  o_sel_a,
    output logic [0:1]  o_sel_b,
    output logic [0:15] o_imm,
    output logic [0:15] o_pc,
    output logic        o_halted,
    output logic [1:0]  o_dbg_state
);

    // Handshakes: memory returns data when i_mem_ack is high while o_mem_req is high;
    // downstream accepts an instruction on a cycle with o_valid && i_ready && !i_redirect.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [0:15] pc, pc_next;
    logic [0:15] ir, ir_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        if (i_redirect) begin
            // Redirect wins over ack and ready: in-flight data or held word is dropped.
            state_next = S_FETCH;
            pc_next    = i_target;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_mem_ack) begin
                        ir_next    = i_mem_data;
                        state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        if (ir[0:4] == HALT_OP) begin
                            state_next = S_HALT;
                        end else begin
                            pc_next    = pc + 16'd1;
                            state_next = S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        o_mem_req   = (state == S_FETCH) && !i_rst;
        o_valid     = (state == S_HOLD) && !i_rst;
        o_halted    = (state == S_HALT) && !i_rst;
        o_mem_addr  = pc;
        o_pc        = pc;
        o_opcode    = 5'b00000;
        o_sel_a     = 2'b00;
        o_sel_b     = 2'b00;
        o_imm       = 16'h0000;
        o_dbg_state = state;
        if (!i_rst) begin
            o_opcode = ir[0:4];
            o_sel_a  = ir[5:6];
            o_sel_b  = ir[7:8];
            o_imm    = {{9{ir[9]}}, ir[9:15]};
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_fetch_decode;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [0:15] mem_addr;
    logic        mem_ack;
    logic [0:15] mem_data;
    logic        redirect;
    logic [0:15] target;
    logic        valid;
    logic        ready;
    logic [0:4]  opcode;
    logic [0:1]  sel_a;
    logic [0:1]  sel_b;
    logic [0:15] imm;
    logic [0:15] pc;
    logic        halted;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    fetch_decode dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_data  (mem_data),
        .i_redirect  (redirect),
        .i_target    (target),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_opcode    (opcode),
        .o_sel_a     (sel_a),
        .o_sel_b     (sel_b),
        .o_imm       (imm),
        .o_pc        (pc),
        .o_halted    (halted),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts downstream acceptances as seen at each rising edge.
    always @(posedge clk) begin
        if (!rst && valid && ready && !redirect) accepts <= accepts + 1;
    end

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ack = 1'b0; mem_data = 16'h0000; redirect = 1'b0; target = 16'h0000; ready = 1'b0;
    endtask

    // Redirect to addr, then deliver word in the following fetch cycle; ends in HOLD.
    task automatic load_word(input logic [0:15] addr, input logic [0:15] word);
        idle_inputs();
        redirect = 1'b1; target = addr;
        step();
        redirect = 1'b0; mem_ack = 1'b1; mem_data = word;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        mem_ack = 1'b1; mem_data = 16'hFFFF; ready = 1'b1; redirect = 1'b1; target = 16'h5555;
        step(); step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if ({opcode, sel_a, sel_b, imm} !== 25'd0) begin errors++; $display("FAIL reset_decode: got %h expected 0", {opcode, sel_a, sel_b, imm}); end
    endtask

    task automatic test_first_fetch();
        int acc0;
        idle_inputs();
        rst = 1'b0; mem_ack = 1'b1; mem_data = 16'h0A5C; ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", mem_req, mem_addr); end
        acc0 = accepts;
        step();
        mem_ack = 1'b0; mem_data = 16'hFFFF;
        #1;
        checks++; if (valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL first_valid: got valid=%b req=%b expected valid=1 req=0", valid, mem_req); end
        checks++; if (opcode !== 5'b00001 || sel_a !== 2'b01 || sel_b !== 2'b00) begin errors++; $display("FAIL first_fields: got op=%b a=%b b=%b expected op=00001 a=01 b=00", opcode, sel_a, sel_b); end
        checks++; if (imm !== 16'hFFDC || pc !== 16'h0000) begin errors++; $display("FAIL first_imm_pc: got imm=%h pc=%h expected imm=ffdc pc=0000", imm, pc); end
        step();
        ready = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || valid !== 1'b0) begin errors++; $display("FAIL first_next_addr: got req=%b addr=%h valid=%b expected req=1 addr=0001 valid=0", mem_req, mem_addr, valid); end
        checks++; if (accepts - acc0 !== 1) begin errors++; $display("FAIL first_accepts: got %0d expected 1", accepts - acc0); end
    endtask

    task automatic test_backpressure();
        int acc0;
        int bad;
        load_word(16'h0020, 16'hADBF);
        acc0 = accepts;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid !== 1'b1 || mem_req !== 1'b0 || opcode !== 5'b10101 || sel_a !== 2'b10 ||
                sel_b !== 2'b11 || imm !== 16'h003F || pc !== 16'h0020) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles expected 0", bad); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        #1;
        checks++; if (accepts - acc0 !== 1) begin errors++; $display("FAIL bp_accepts: got %0d expected 1", accepts - acc0); end
        checks++; if (mem_addr !== 16'h0021 || mem_req !== 1'b1) begin errors++; $display("FAIL bp_next_addr: got addr=%h req=%b expected addr=0021 req=1", mem_addr, mem_req); end
    endtask

    task automatic test_redirect_ack();
        idle_inputs();
        mem_ack = 1'b1; mem_data = 16'h0A5C; redirect = 1'b1; target = 16'h1234;
        step();
        idle_inputs();
        #1;
        checks++; if (valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h1234) begin errors++; $display("FAIL redir_ack: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=1234", valid, mem_req, mem_addr); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_no_pulse: got valid=%b expected 0", valid); end
    endtask

    task automatic test_redirect_hold();
        int acc0;
        load_word(16'h0300, 16'h0A5C);
        acc0 = accepts;
        ready = 1'b1; redirect = 1'b1; target = 16'h0777;
        step();
        idle_inputs();
        #1;
        checks++; if (accepts !== acc0 || valid !== 1'b0 || mem_addr !== 16'h0777) begin errors++; $display("FAIL redir_hold: got acc=%0d valid=%b addr=%h expected acc=%0d valid=0 addr=0777", accepts, valid, mem_addr, acc0); end
    endtask

    task automatic test_halt();
        load_word(16'h0100, 16'hF800);
        checks++; if (valid !== 1'b1 || opcode !== 5'b11111) begin errors++; $display("FAIL halt_hold: got valid=%b op=%b expected valid=1 op=11111", valid, opcode); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || valid !== 1'b0 || pc !== 16'h0100) begin errors++; $display("FAIL halt_state: got halted=%b req=%b valid=%b pc=%h expected 1 0 0 0100", halted, mem_req, valid, pc); end
            mem_ack = 1'b1; mem_data = 16'h0A5C;
            step();
        end
        idle_inputs();
        redirect = 1'b1; target = 16'h0040;
        step();
        redirect = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0 1 0040", halted, mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        load_word(16'hFFFF, 16'h1234);
        checks++; if (pc !== 16'hFFFF || opcode !== 5'b00010) begin errors++; $display("FAIL wrap_hold: got pc=%h op=%b expected ffff 00010", pc, opcode); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got addr=%h req=%b expected 0000 1", mem_addr, mem_req); end
    endtask

    task automatic test_reset_in_hold();
        int acc0;
        load_word(16'h0005, 16'h0A5C);
        acc0 = accepts;
        rst = 1'b1; ready = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || mem_req !== 1'b0 || opcode !== 5'b00000) begin errors++; $display("FAIL rst_hold_quiet: got valid=%b req=%b op=%b expected 0 0 00000", valid, mem_req, opcode); end
        step();
        rst = 1'b0; ready = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'h0000 || valid !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL rst_hold_after: got addr=%h valid=%b req=%b expected 0000 0 1", mem_addr, valid, mem_req); end
        checks++; if (accepts !== acc0) begin errors++; $display("FAIL rst_hold_accepts: got %0d expected %0d", accepts, acc0); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        // Zero-latency memory and always-ready sink: one instruction every two cycles.
        idle_inputs();
        redirect = 1'b1; target = 16'h0200;
        step();
        redirect = 1'b0; mem_ack = 1'b1; mem_data = 16'h0A5C; ready = 1'b1;
        acc0 = accepts;
        for (int i = 0; i < 8; i++) step();
        idle_inputs();
        #1;
        checks++; if (accepts - acc0 !== 4 || mem_addr !== 16'h0204) begin errors++; $display("FAIL b2b: got acc=%0d addr=%h expected 4 0204", accepts - acc0, mem_addr); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_ack();
        test_redirect_hold();
        test_halt();
        test_wrap();
        test_reset_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
